// File: rtl/mul_wb_stage.sv
// M5 writeback stage of the multiply pipeline: a 2-entry in-order skid FIFO
// that arbitrates for the ROB write port and back-pressures M1-M4.
module mul_wb_stage #(
   parameter int WORD_SIZE       = 32,
   parameter int INSTR_TYPE_SZ   = 3,
   parameter int ROB_ENTRY_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
   input  logic [WORD_SIZE-1:0]       in_pc,
   input  logic [WORD_SIZE-1:0]       in_result,
   input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
   input  logic                       flush,
   input  logic                       rob_grant,
   output logic                       stall,
   output logic                       rob_req,
   output logic [INSTR_TYPE_SZ-1:0]   instruction_type_out,
   output logic [WORD_SIZE-1:0]       pc_out,
   output logic [WORD_SIZE-1:0]       result_out,
   output logic [ROB_ENTRY_WIDTH-1:0] rob_id_out,
   output logic                       wb_fire,
   output logic [31:0]                stall_cycles
);

   typedef struct packed {
      logic [INSTR_TYPE_SZ-1:0]   itype;
      logic [WORD_SIZE-1:0]       pc;
      logic [WORD_SIZE-1:0]       result;
      logic [ROB_ENTRY_WIDTH-1:0] rob_id;
   } entry_t;

   entry_t     mem [2];
   logic       head;
   logic       tail;
   logic [1:0] count;
   logic       push;

   // stall depends only on registered occupancy, keeping it off any grant path
   assign stall   = (count == 2'd2);
   assign rob_req = (count != 2'd0) && !flush;
   assign wb_fire = rob_req && rob_grant;
   assign push    = in_valid && !stall && !flush;

   assign instruction_type_out = mem[head].itype;
   assign pc_out               = mem[head].pc;
   assign result_out           = mem[head].result;
   assign rob_id_out           = mem[head].rob_id;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head         <= 1'b0;
         tail         <= 1'b0;
         count        <= 2'd0;
         stall_cycles <= 32'd0;
         for (int i = 0; i < 2; i++) mem[i] <= '0;
      end else begin
         if (stall && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
         if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
         end else begin
            if (push) begin
               mem[tail] <= '{itype: in_instruction_type, pc: in_pc,
                              result: in_result, rob_id: in_rob_id};
               tail      <= ~tail;
            end
            if (wb_fire) head <= ~head;
            case ({push, wb_fire})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_wb_stage.sv
// Bench for mul_wb_stage: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mul_wb_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  in_instruction_type = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_result = '0;
   logic [3:0]  in_rob_id = '0;
   logic        flush = 1'b0;
   logic        rob_grant = 1'b0;
   logic        stall, rob_req, wb_fire;
   logic [2:0]  instruction_type_out;
   logic [31:0] pc_out, result_out, stall_cycles;
   logic [3:0]  rob_id_out;

   mul_wb_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .in_instruction_type(in_instruction_type), .in_pc(in_pc),
      .in_result(in_result), .in_rob_id(in_rob_id), .flush(flush),
      .rob_grant(rob_grant), .stall(stall), .rob_req(rob_req),
      .instruction_type_out(instruction_type_out), .pc_out(pc_out),
      .result_out(result_out), .rob_id_out(rob_id_out),
      .wb_fire(wb_fire), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  t;
      logic [31:0] pc;
      logic [31:0] res;
      logic [3:0]  id;
   } ent_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   bit          chk_on  = 1'b0;
   ent_t        m_q[$];
   logic [31:0] m_stall = 0;
   logic [31:0] wr_res[$];
   bit          m_full, m_fire, m_push;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // reference model: a FIFO of accepted ops, at most two deep
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q.delete();
         m_stall = 0;
      end else begin
         m_full = (m_q.size() == 2);
         m_fire = (m_q.size() != 0) && !flush && rob_grant;
         m_push = in_valid && !m_full && !flush;
         if (m_full && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (flush) m_q.delete();
         else begin
            if (m_fire) void'(m_q.pop_front());
            if (m_push) m_q.push_back('{t: in_instruction_type, pc: in_pc,
                                        res: in_result, id: in_rob_id});
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on && reset === 1'b1) begin
         chk("stall", 64'(stall), 64'(m_q.size() == 2));
         chk("rob_req", 64'(rob_req), 64'(m_q.size() != 0 && !flush));
         chk("wb_fire", 64'(wb_fire), 64'(m_q.size() != 0 && !flush && rob_grant));
         chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
         if (m_q.size() != 0) begin
            chk("rob_id_out", 64'(rob_id_out), 64'(m_q[0].id));
            chk("result_out", 64'(result_out), 64'(m_q[0].res));
            chk("pc_out", 64'(pc_out), 64'(m_q[0].pc));
            chk("type_out", 64'(instruction_type_out), 64'(m_q[0].t));
         end
         if (wb_fire) wr_res.push_back(result_out);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] id, input logic [31:0] res);
      in_valid            = 1'b1;
      in_rob_id           = id;
      in_result           = res;
      in_pc               = res ^ 32'h0000_1000;
      in_instruction_type = id[2:0];
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int w;
      int bad;
      #12;
      reset = 1'b1;
      #1;
      chk("rst_rob_req", 64'(rob_req), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_wb_fire", 64'(wb_fire), 64'd0);
      chk("rst_result", 64'(result_out), 64'd0);
      chk("rst_pc", 64'(pc_out), 64'd0);
      chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
      chk_on = 1'b1;

      // single op, one-cycle latency to rob_req
      step();
      send(4'd3, 32'h0000_0042);
      rob_grant = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      chk("t1_rob_req", 64'(rob_req), 64'd1);
      chk("t1_rob_id", 64'(rob_id_out), 64'd3);
      chk("t1_result", 64'(result_out), 64'h42);
      chk("t1_wb_fire", 64'(wb_fire), 64'd1);
      step();
      chk("t1_empty", 64'(rob_req), 64'd0);
      chk("t1_no_stall", 64'(stall_cycles), 64'd0);

      // back-pressure: three ops with no grant
      rob_grant = 1'b0;
      send(4'd1, 32'hB000_0001);
      step();
      send(4'd2, 32'hB000_0002);
      step();
      send(4'd3, 32'hB000_0003);
      chk("t2_stall_up", 64'(stall), 64'd1);
      step(); step(); step();
      chk("t2_stall_cycles3", 64'(stall_cycles), 64'd3);
      rob_grant = 1'b1;
      step();
      chk("t2_stall_drop", 64'(stall), 64'd0);
      chk("t2_stall_cycles4", 64'(stall_cycles), 64'd4);
      chk("t2_head2", 64'(rob_id_out), 64'd2);
      step();
      in_valid = 1'b0;
      chk("t2_head3", 64'(rob_id_out), 64'd3);
      step();
      chk("t2_drained", 64'(rob_req), 64'd0);
      chk("t2_wr_cnt", 64'(wr_res.size()), 64'd4);
      if (wr_res.size() == 4) begin
         chk("t2_order1", 64'(wr_res[1]), 64'hB000_0001);
         chk("t2_order2", 64'(wr_res[2]), 64'hB000_0002);
         chk("t2_order3", 64'(wr_res[3]), 64'hB000_0003);
      end

      // streaming with random grant
      for (int i = 0; i < 20; i++) begin
         send(4'(i), 32'hC000_0000 + 32'(i));
         w = 0;
         do begin
            rob_grant = 1'($urandom_range(0, 1));
            acc = !stall;
            step();
            w++;
         end while (!acc && w < 50);
         if (!acc) chk("t3_accept_timeout", 64'd0, 64'd1);
      end
      in_valid  = 1'b0;
      rob_grant = 1'b1;
      w = 0;
      while (rob_req && w < 10) begin step(); w++; end
      chk("t3_drained", 64'(rob_req), 64'd0);
      chk("t3_wr_cnt", 64'(wr_res.size()), 64'd24);
      for (int i = 0; i < 20 && i + 4 < wr_res.size(); i++)
         chk("t3_order", 64'(wr_res[i+4]), 64'(32'hC000_0000 + 32'(i)));

      // flush with a full FIFO and a held input
      rob_grant = 1'b0;
      send(4'd5, 32'hDEAD_0005);
      step();
      send(4'd6, 32'hDEAD_0006);
      step();
      send(4'd7, 32'hDEAD_0007);
      flush     = 1'b1;
      rob_grant = 1'b1;
      #1;
      chk("t4_req_in_flush", 64'(rob_req), 64'd0);
      chk("t4_fire_in_flush", 64'(wb_fire), 64'd0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("t4_stall_after", 64'(stall), 64'd0);
      chk("t4_req_after", 64'(rob_req), 64'd0);
      send(4'd8, 32'h0000_0808);
      step();
      in_valid = 1'b0;
      chk("t4_next_id", 64'(rob_id_out), 64'd8);
      chk("t4_next_res", 64'(result_out), 64'h808);
      step();

      // asynchronous reset mid-cycle with a full FIFO
      rob_grant = 1'b0;
      send(4'd9, 32'hDEAD_0009);
      step();
      send(4'd10, 32'hDEAD_000A);
      step();
      send(4'd11, 32'hDEAD_000B);
      step();
      chk("t5_full", 64'(stall), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("t5_req", 64'(rob_req), 64'd0);
      chk("t5_stall", 64'(stall), 64'd0);
      chk("t5_stall_cycles", 64'(stall_cycles), 64'd0);
      chk("t5_result", 64'(result_out), 64'd0);
      chk("t5_rob_id", 64'(rob_id_out), 64'd0);
      in_valid = 1'b0;
      step();
      reset = 1'b1;

      // pointer wrap with alternating grant delay
      for (int i = 0; i < 6; i++) begin
         send(4'(i), 32'h6000_0000 + 32'(i));
         rob_grant = (i % 2 == 0);
         step();
         in_valid = 1'b0;
         if (i % 2 == 1) begin step(); rob_grant = 1'b1; end
         step();
      end
      chk("t6_wr_cnt", 64'(wr_res.size()), 64'd31);
      for (int i = 0; i < 6 && i + 25 < wr_res.size(); i++)
         chk("t6_order", 64'(wr_res[i+25]), 64'(32'h6000_0000 + 32'(i)));

      bad = 0;
      foreach (wr_res[k]) if (wr_res[k][31:16] == 16'hDEAD) bad++;
      chk("discarded_never_written", 64'(bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
